// File: rtl/aes128_key_sched.sv
// AES-128 key-schedule controller: expands a 128-bit key into w[0..43], one
// word per valid/ready handshake, sharing a single SubWord instance.

module aes_sub_word (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  // Entry 0 sits in the most-significant byte, so sbox_tab[x] is S(x).
  localparam logic [0:255][7:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign dout = {sbox_tab[din[31:24]], sbox_tab[din[23:16]],
                 sbox_tab[din[15:8]],  sbox_tab[din[7:0]]};

endmodule

module aes128_key_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         word_ready,
  output logic         word_valid,
  output logic [31:0]  word_out,
  output logic [5:0]   word_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  logic [127:0] win;
  logic [5:0]   idx;
  logic [7:0]   rcon;
  logic         done_q;

  logic [31:0]  win_a;
  logic [31:0]  win_d;
  logic [31:0]  rot_d;
  logic [31:0]  sub_rot_d;
  logic [31:0]  key_word;
  logic [31:0]  temp;
  logic [31:0]  next_word;
  logic         emitting;
  logic         handshake;
  logic         expanding;
  logic         rcon_step;
  logic [7:0]   rcon_next;

  assign win_a = win[127:96];
  assign win_d = win[31:0];
  assign rot_d = {win_d[23:0], win_d[31:24]};

  aes_sub_word u_sub_word (
    .din  (rot_d),
    .dout (sub_rot_d)
  );

  assign emitting  = (state == EMIT);
  assign handshake = emitting && word_ready;
  assign expanding = (idx >= 6'd4);
  assign rcon_step = expanding && (idx[1:0] == 2'b00);
  assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    key_word = win[127:96];
    case (idx[1:0])
      2'd0: key_word = win[127:96];
      2'd1: key_word = win[95:64];
      2'd2: key_word = win[63:32];
      2'd3: key_word = win[31:0];
      default: key_word = win[127:96];
    endcase
  end

  always_comb begin
    temp = win_d;
    if (rcon_step)
      temp = sub_rot_d ^ {rcon, 24'h0};
  end

  assign next_word = expanding ? (win_a ^ temp) : key_word;

  // Outputs are gated by the registered state so nothing leaks outside EMIT
  // and word_ready never reaches word_out/word_valid combinationally.
  assign word_valid = emitting;
  assign busy       = emitting;
  assign word_out   = emitting ? next_word : 32'h0;
  assign word_idx   = emitting ? idx : 6'd0;
  assign done       = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      win    <= 128'h0;
      idx    <= 6'd0;
      rcon   <= 8'h01;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win   <= key_in;
            idx   <= 6'd0;
            rcon  <= 8'h01;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            idx <= idx + 6'd1;
            if (expanding)
              win <= {win[95:0], next_word};
            if (rcon_step)
              rcon <= rcon_next;
            if (idx == 6'd43) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_key_sched.sv
// Directed bench for aes128_key_sched: FIPS-197 and zero-key vectors,
// backpressure, reset mid-run, ignored start and back-to-back expansions.

module tb_aes128_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         word_ready;
  logic         word_valid;
  logic [31:0]  word_out;
  logic [5:0]   word_idx;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_w [44];
  logic [31:0] got_w [44];

  localparam logic [127:0] fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] zero_key = 128'h0;

  localparam logic [0:255][7:0] sbox_ref = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] rcon_ref = 80'h01020408102040801b36;

  aes128_key_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word_out   (word_out),
    .word_idx   (word_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Textbook word-array expansion, independent of the sliding-window RTL.
  task automatic build_model(input logic [127:0] key);
    logic [31:0] t;
    for (int i = 0; i < 4; i++)
      exp_w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = exp_w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
        t = t ^ {rcon_ref[i/4 - 1], 24'h0};
      end
      exp_w[i] = exp_w[i-4] ^ t;
    end
  endtask

  // mode 0: ready held high; 1: backpressure; 2: stray start at word 10;
  // 3: start raised at word 43 and left high through done.
  task automatic expand(input logic [127:0] key, input int mode);
    int count = 0;
    int cyc = 0;
    int s3 = 0, s4 = 0, s39 = 0;
    logic ready;
    logic pstall = 1'b0;
    logic [31:0] pw = 32'h0;
    logic [5:0] pi = 6'd0;
    build_model(key);
    @(negedge clk);
    key_in = key;
    start = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_in = ~key;
    while (count < 44 && cyc < 400) begin
      cyc++;
      if (pstall) begin
        check("hold_word", word_out, pw);
        check("hold_idx", word_idx, pi);
      end
      if (mode == 0) check("valid_run", word_valid, 1'b1);
      check("busy_run", busy, 1'b1);
      ready = 1'b1;
      if (mode == 1) begin
        if (word_idx == 6'd3 && s3 < 3) begin ready = 1'b0; s3++; end
        else if (word_idx == 6'd4 && s4 < 3) begin ready = 1'b0; s4++; end
        else if (word_idx == 6'd39 && s39 < 3) begin ready = 1'b0; s39++; end
        else ready = ($urandom_range(0, 3) != 0);
      end
      if (mode == 2) start = (count == 10);
      if (mode == 3 && count == 43) begin
        start = 1'b1;
        key_in = key;
      end
      word_ready = ready;
      if (word_valid) begin
        check("word_idx", word_idx, count);
        check("word_out", word_out, exp_w[count]);
        got_w[count] = word_out;
      end
      pstall = word_valid && !ready;
      pw = word_out;
      pi = word_idx;
      if (word_valid && ready) count++;
      @(negedge clk);
    end
    if (count < 44) check("timeout", count, 44);
    check("done_pulse", done, 1'b1);
    check("busy_end", busy, 1'b0);
    check("valid_end", word_valid, 1'b0);
    check("word_out_idle", word_out, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, word_valid, 1'b0);
    check({tag, "_out"}, word_out, 32'h0);
    check({tag, "_idx"}, word_idx, 6'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0;
    key_in = 128'h0;
    word_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // FIPS-197 vector, no stalls
    expand(fips_key, 0);
    check("fips_w0", got_w[0], 32'h2b7e1516);
    check("fips_w4", got_w[4], 32'ha0fafe17);
    check("fips_w8", got_w[8], 32'hf2c295f2);
    check("fips_w40", got_w[40], 32'hd014f9a8);
    check("fips_w43", got_w[43], 32'hb6630ca6);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);

    // All-zero key
    expand(zero_key, 0);
    check("zero_w4", got_w[4], 32'h62636363);
    check("zero_w40", got_w[40], 32'hb4ef5bcb);
    check("zero_w43", got_w[43], 32'h6f8f188e);

    // Backpressure with the FIPS key
    expand(fips_key, 1);
    check("bp_w43", got_w[43], 32'hb6630ca6);

    // Reset in the middle of an expansion
    @(negedge clk);
    key_in = fips_key;
    start = 1'b1;
    word_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (word_idx != 6'd20 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("reach_idx20", word_idx, 6'd20);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");
    expand(zero_key, 0);
    check("restart_w0", got_w[0], 32'h0);
    check("restart_w4", got_w[4], 32'h62636363);

    // Stray start during EMIT with a different key
    expand(fips_key, 2);
    check("ignored_w40", got_w[40], 32'hd014f9a8);
    start = 1'b0;

    // start held through the done cycle launches the next run at once
    expand(fips_key, 3);
    @(negedge clk);
    check("b2b_valid", word_valid, 1'b1);
    check("b2b_idx", word_idx, 6'd0);
    check("b2b_w0", word_out, 32'h2b7e1516);
    check("b2b_done_low", done, 1'b0);
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_key_sched.md
# aes128_key_sched

Sequential AES-128 key-schedule controller. It expands a 128-bit cipher key into the 44 round-key words w[0]..w[43] and produces one word per accepted handshake. A single shared SubWord instance (four S-Box lookups) serves every word where i mod 4 = 0. The block sits between the key register and the round-key consumer, either the cipher round controller or a round-key RAM writer.

## Interface
- No parameters (AES-128 only: Nk=4, 44 words).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an expansion; sampled only in IDLE.
- key_in  in  128  cipher key; w[0]=key_in[127:96] … w[3]=key_in[31:0]; latched on accepted start.
- word_ready  in  1  consumer accepts word_out this cycle.
- word_valid  out  1  word_out/word_idx hold a valid word.
- word_out  out  32  current round-key word w[word_idx].
- word_idx  out  6  index 0..43 of word_out.
- busy  out  1  high from the cycle after accepted start through the last handshake.
- done  out  1  one-cycle pulse after w[43] is accepted.

## Operation
- State: IDLE, EMIT.
  - IDLE→EMIT on start.
  - EMIT→IDLE on handshake (word_valid & word_ready) with idx=43.
- Registers:
  - win[127:0]: four-word window.
  - idx[5:0].
  - rcon[7:0].
  - state.
  - done flag.
- Accepted start (IDLE & start):
  - win<=key_in, idx<=0, rcon<=8'h01.
- EMIT output word:
  - idx<4: word_out = win word idx (the key word, window unchanged).
  - idx≥4, window = {a,b,c,d} = w[i-4..i-1]:
    - If idx mod 4 = 0: temp = SubWord(RotWord(d)) ^ {rcon,24'h0}, where RotWord(d) = {d[23:0],d[31:24]}.
    - Otherwise: temp = d.
    - word_out = a ^ temp.
- On handshake in EMIT:
  - idx<=idx+1.
  - If idx≥4: win<={b,c,d,word_out}.
  - If idx≥4 and idx mod 4 = 0: rcon<=xtime(rcon) = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1B : 8'h00).
- Rcon sequence used at idx 4,8,…,40: 01,02,04,08,10,20,40,80,1B,36.
- Only one SubWord instance exists; it is driven from RotWord(win[31:0]) continuously. Its output is used only when idx mod 4 = 0 and idx≥4.
- Backpressure: while word_valid & !word_ready, word_out, word_idx and all registers hold.
- start in EMIT is ignored; key_in is don't-care outside the accepting cycle.

## Timing
- Reset values: word_valid=0, word_out=0, word_idx=0, busy=0, done=0, state=IDLE, rcon=8'h01, win=0.
- Reset asserted mid-expansion: next edge returns to IDLE with the reset values above. No done pulse; the partial expansion is abandoned.
- start sampled at edge T: word_valid=1, busy=1, word_idx=0 from cycle T+1.
- With word_ready held high, words 0..43 appear on consecutive cycles T+1..T+44.
  - Handshake of w[43] at the edge ending T+44.
  - At T+45: done=1, busy=0, word_valid=0, state IDLE.
- done is high exactly one cycle. A start asserted in the done cycle is accepted (state is IDLE).
- word_valid=busy in EMIT.
- word_out is combinational from registers through one SubWord. No combinational path from word_ready to word_out/word_valid.
- word_out = 0 whenever word_valid=0.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, word_ready=1:
  - w0=2b7e1516, w4=a0fafe17, w8=f2c295f2, w40=d014f9a8, w43=b6630ca6.
  - 44 consecutive valid cycles, done at T+45.
- All-zero key:
  - w4=62636363, w40=b4ef5bcb, w43=6f8f188e.
  - Full 44-word dump matches the reference model.
- Backpressure: FIPS key, word_ready toggling pseudo-randomly with 3-cycle stalls at idx 3, 4 and 39.
  - Words and idx stay stable during stalls.
  - Sequence is identical to the no-stall run.
- rst asserted at idx=20, then start with the zero key:
  - Outputs return to reset values the next cycle, with no done pulse.
  - The new run starts at w0=00000000 and gives w4=62636363 (rcon restarted at 01).
- start pulsed at idx=10 with a different key_in: ignored, expansion continues with the original key.
- start held high through the done cycle: a second expansion begins immediately, with word_valid high on the following cycle.
